divisor_sinal_fila: RTL and testbench

//  Parametrised successor to the instruction field splitter: decodes MIPS-32 words into fields,

---
 rtl/divisor_sinal_fila_if.sv | 55 +++++
 rtl/divisor_sinal_fila.sv | 168 ++++++++++++++++
 tb/tb_divisor_sinal_fila.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/divisor_sinal_fila_if.sv
// ---------------------------------------------------------------------------
// divisor_sinal_fila_if
// Bundle between the instruction source / decode consumer and the
// divisor_sinal_fila decode FIFO.
//   master : the side that supplies instruction words and consumes decoded fields
//   slave  : the decode FIFO itself
// Signals
//   cont, flush, in_valid, instrucao, out_ready              (master -> slave)
//   in_ready, out_valid, opCode, rA, rB, rC, shamt, funct,
//   imm_ext, jump, tipo, count                               (slave -> master)
//   ilegal (only when DIVISOR_ILEGAL_EN is defined)          (slave -> master)
// ---------------------------------------------------------------------------
interface divisor_sinal_fila_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
);
    logic [3:0]              cont;
    logic                    flush;
    logic                    in_valid;
    logic                    in_ready;
    logic [31:0]             instrucao;
    logic                    out_valid;
    logic                    out_ready;
    logic [5:0]              opCode;
    logic [4:0]              rA;
    logic [4:0]              rB;
    logic [4:0]              rC;
    logic [4:0]              shamt;
    logic [5:0]              funct;
    logic [XLEN-1:0]         imm_ext;
    logic [25:0]             jump;
    logic [1:0]              tipo;
    logic [$clog2(DEPTH):0]  count;
`ifdef DIVISOR_ILEGAL_EN
    logic                    ilegal;
`endif

    modport master (
        output cont, flush, in_valid, instrucao, out_ready,
        input  in_ready, out_valid, opCode, rA, rB, rC, shamt, funct,
               imm_ext, jump, tipo, count
`ifdef DIVISOR_ILEGAL_EN
        , input ilegal
`endif
    );

    modport slave (
        input  cont, flush, in_valid, instrucao, out_ready,
        output in_ready, out_valid, opCode, rA, rB, rC, shamt, funct,
               imm_ext, jump, tipo, count
`ifdef DIVISOR_ILEGAL_EN
        , output ilegal
`endif
    );
endinterface

// File: rtl/divisor_sinal_fila.sv
// ---------------------------------------------------------------------------
// divisor_sinal_fila
// Decodes MIPS-32 instruction words into their fields, extends the 16-bit
// immediate, classifies the word as R/I/J and buffers the result in a
// DEPTH-entry show-ahead FIFO so fetch is decoupled from decode stalls.
// Parameters
//   XLEN     : width of imm_ext (>=16)
//   DEPTH    : FIFO entries (power of 2, >=2)
//   MODE     : 0 = capture on cont==LOAD_CNT, 1 = capture on in_valid&&in_ready
//   LOAD_CNT : cont value that triggers a capture in MODE 0
// Ports
//   clk  : clock, all state on the rising edge
//   rst  : synchronous active-high reset
//   bus  : divisor_sinal_fila_if.slave (input word/strobes, decoded head entry,
//          occupancy count, handshake)
// Optional feature macro: DIVISOR_ILEGAL_EN adds a per-entry ilegal flag on
// bus.ilegal marking unsupported opcodes / R-type functs.
// ---------------------------------------------------------------------------
module divisor_sinal_fila #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 2,
    parameter int MODE     = 1,
    parameter int LOAD_CNT = 3
) (
    input  logic               clk,
    input  logic               rst,
    divisor_sinal_fila_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // andi/ori/xori take a zero-extended immediate, everything else sign-extends
    function automatic logic [XLEN-1:0] ext_imm(input logic [31:0] word);
        logic [XLEN-1:0] res;
        if (word[31:26] == 6'h0C || word[31:26] == 6'h0D || word[31:26] == 6'h0E) begin
            res = XLEN'(word[15:0]);
        end else begin
            res = XLEN'(signed'(word[15:0]));
        end
        return res;
    endfunction

    function automatic logic [1:0] classify(input logic [5:0] op);
        logic [1:0] res;
        case (op)
            6'h00:         res = 2'b00;
            6'h02, 6'h03:  res = 2'b10;
            default:       res = 2'b01;
        endcase
        return res;
    endfunction

`ifdef DIVISOR_ILEGAL_EN
    function automatic logic is_ilegal(input logic [5:0] op, input logic [5:0] fn);
        logic res;
        case (op)
            6'h00: begin
                case (fn)
                    6'h00, 6'h02, 6'h08, 6'h20, 6'h21, 6'h22, 6'h23,
                    6'h24, 6'h25, 6'h26, 6'h27, 6'h2A: res = 1'b0;
                    default:                           res = 1'b1;
                endcase
            end
            6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
            6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B: res = 1'b0;
            default:                                  res = 1'b1;
        endcase
        return res;
    endfunction

    logic                ilegal_mem_r [DEPTH];
`endif

    logic [31:0]         word_mem_r [DEPTH];
    logic [XLEN-1:0]     imm_mem_r  [DEPTH];
    logic [1:0]          tipo_mem_r [DEPTH];
    logic [AW-1:0]       wr_ptr_r;
    logic [AW-1:0]       rd_ptr_r;
    logic [CW-1:0]       count_r;
    logic                out_valid_r;

    logic                pop_s;
    logic                push_s;
    logic                strobe_s;
    logic                in_ready_s;
    logic [CW-1:0]       count_nxt_s;

    // Handshake: a full FIFO still accepts a word when the head leaves this cycle
    always_comb begin
        pop_s      = out_valid_r && bus.out_ready;
        in_ready_s = !rst && ((count_r < CW'(DEPTH)) || pop_s);
        if (MODE == 0) begin
            strobe_s = (bus.cont == 4'(LOAD_CNT));
        end else begin
            strobe_s = bus.in_valid;
        end
        push_s = strobe_s && in_ready_s;
    end

    // Next occupancy; flush wins over any same-cycle push
    always_comb begin
        count_nxt_s = count_r;
        if (bus.flush) begin
            count_nxt_s = '0;
        end else if (push_s && !pop_s) begin
            count_nxt_s = count_r + CW'(1);
        end else if (pop_s && !push_s) begin
            count_nxt_s = count_r - CW'(1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // FIFO storage, pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            out_valid_r <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                word_mem_r[i]   <= 32'h0000_0000;
                imm_mem_r[i]    <= '0;
                tipo_mem_r[i]   <= 2'b00;
`ifdef DIVISOR_ILEGAL_EN
                ilegal_mem_r[i] <= 1'b0;
`endif
            end
        end else begin
            count_r     <= count_nxt_s;
            out_valid_r <= (count_nxt_s != '0);
            if (bus.flush) begin
                wr_ptr_r <= '0;
                rd_ptr_r <= '0;
            end else begin
                if (push_s) begin
                    word_mem_r[wr_ptr_r]   <= bus.instrucao;
                    imm_mem_r[wr_ptr_r]    <= ext_imm(bus.instrucao);
                    tipo_mem_r[wr_ptr_r]   <= classify(bus.instrucao[31:26]);
`ifdef DIVISOR_ILEGAL_EN
                    ilegal_mem_r[wr_ptr_r] <= is_ilegal(bus.instrucao[31:26], bus.instrucao[5:0]);
`endif
                    wr_ptr_r <= wr_ptr_r + AW'(1);
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + AW'(1);
                end
            end
        end
    end

    // Show-ahead: decoded fields come straight from the head slot
    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.count     = count_r;
    assign bus.opCode    = word_mem_r[rd_ptr_r][31:26];
    assign bus.rA        = word_mem_r[rd_ptr_r][25:21];
    assign bus.rB        = word_mem_r[rd_ptr_r][20:16];
    assign bus.rC        = word_mem_r[rd_ptr_r][15:11];
    assign bus.shamt     = word_mem_r[rd_ptr_r][10:6];
    assign bus.funct     = word_mem_r[rd_ptr_r][5:0];
    assign bus.jump      = word_mem_r[rd_ptr_r][25:0];
    assign bus.imm_ext   = imm_mem_r[rd_ptr_r];
    assign bus.tipo      = tipo_mem_r[rd_ptr_r];
`ifdef DIVISOR_ILEGAL_EN
    assign bus.ilegal    = ilegal_mem_r[rd_ptr_r];
`endif
endmodule

// File: tb/tb_divisor_sinal_fila.sv
// ---------------------------------------------------------------------------
// tb_divisor_sinal_fila
// Two instances: u_dut1 (MODE 1, handshake) and u_dut0 (MODE 0, cont strobe),
// both XLEN=32, DEPTH=2. Decoded fields are checked against a queue-based
// reference built from the instruction-set rules.
// ---------------------------------------------------------------------------
module tb_divisor_sinal_fila;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    divisor_sinal_fila_if #(.XLEN(32), .DEPTH(2)) b1 ();
    divisor_sinal_fila_if #(.XLEN(32), .DEPTH(2)) b0 ();

    divisor_sinal_fila #(.XLEN(32), .DEPTH(2), .MODE(1), .LOAD_CNT(3))
        u_dut1 (.clk(clk), .rst(rst), .bus(b1));
    divisor_sinal_fila #(.XLEN(32), .DEPTH(2), .MODE(0), .LOAD_CNT(3))
        u_dut0 (.clk(clk), .rst(rst), .bus(b0));

    typedef struct {
        logic [31:0] instr;
        logic [5:0]  op;
        logic [31:0] imm;
        logic [1:0]  tipo;
    } vec_t;

    vec_t vecs [10];
    logic [31:0] q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_imm(input logic [31:0] w);
        int v;
        if (w[31:26] inside {6'h0C, 6'h0D, 6'h0E}) return {16'h0000, w[15:0]};
        v = $signed(w[15:0]);
        return 32'(v);
    endfunction

    function automatic logic [1:0] ref_tipo(input logic [31:0] w);
        if (w[31:26] == 6'h00) return 2'b00;
        if (w[31:26] inside {6'h02, 6'h03}) return 2'b10;
        return 2'b01;
    endfunction

    function automatic logic ref_ilegal(input logic [31:0] w);
        logic [5:0] op;
        logic [5:0] fn;
        op = w[31:26];
        fn = w[5:0];
        if (!(op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
                         6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B})) return 1'b1;
        if (op == 6'h00 && !(fn inside {6'h00, 6'h02, 6'h08, 6'h20, 6'h21, 6'h22,
                                        6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A})) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check_head(input string tag, input logic [31:0] w);
        check({tag, ".opCode"},  b1.opCode,  w[31:26]);
        check({tag, ".rA"},      b1.rA,      w[25:21]);
        check({tag, ".rB"},      b1.rB,      w[20:16]);
        check({tag, ".rC"},      b1.rC,      w[15:11]);
        check({tag, ".shamt"},   b1.shamt,   w[10:6]);
        check({tag, ".funct"},   b1.funct,   w[5:0]);
        check({tag, ".jump"},    b1.jump,    w[25:0]);
        check({tag, ".imm_ext"}, b1.imm_ext, ref_imm(w));
        check({tag, ".tipo"},    b1.tipo,    ref_tipo(w));
`ifdef DIVISOR_ILEGAL_EN
        check({tag, ".ilegal"},  b1.ilegal,  ref_ilegal(w));
`endif
    endtask

    // push one word into u_dut1 and leave the inputs idle at the next negedge
    task automatic push1(input logic [31:0] w);
        @(negedge clk);
        b1.in_valid  = 1'b1;
        b1.instrucao = w;
        @(posedge clk);
        @(negedge clk);
        b1.in_valid  = 1'b0;
        #1;
    endtask

    task automatic pop1();
        b1.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b1.out_ready = 1'b0;
    endtask

    initial begin
        vecs[0] = '{32'h8E510064, 6'h23, 32'h00000064, 2'b01};
        vecs[1] = '{32'h3021FFFF, 6'h0C, 32'h0000FFFF, 2'b01};
        vecs[2] = '{32'h2021FFFF, 6'h08, 32'hFFFFFFFF, 2'b01};
        vecs[3] = '{32'h00221820, 6'h00, 32'h00001820, 2'b00};
        vecs[4] = '{32'h0C000040, 6'h03, 32'h00000040, 2'b10};
        vecs[5] = '{32'h3442F000, 6'h0D, 32'h0000F000, 2'b01};
        vecs[6] = '{32'h38638000, 6'h0E, 32'h00008000, 2'b01};
        vecs[7] = '{32'h3C018000, 6'h0F, 32'hFFFF8000, 2'b01};
        vecs[8] = '{32'h1000FFFE, 6'h04, 32'hFFFFFFFE, 2'b01};
        vecs[9] = '{32'h08000010, 6'h02, 32'h00000010, 2'b10};

        b1.cont = 4'd0; b1.flush = 1'b0; b1.in_valid = 1'b0; b1.instrucao = 32'h0; b1.out_ready = 1'b0;
        b0.cont = 4'd0; b0.flush = 1'b0; b0.in_valid = 1'b0; b0.instrucao = 32'h0; b0.out_ready = 1'b0;

        // reset state
        @(posedge clk);
        @(negedge clk);
        b1.in_valid = 1'b1;
        #1;
        check("rst.in_ready", b1.in_ready, 1'b0);
        check("rst.out_valid", b1.out_valid, 1'b0);
        check("rst.count", b1.count, 3'd0);
        check("rst.imm_ext", b1.imm_ext, 32'h0);
        b1.in_valid = 1'b0;
        rst = 1'b0;

        // lw into empty FIFO: visible right after the push edge
        push1(32'h8E510064);
        check("lw.out_valid", b1.out_valid, 1'b1);
        check("lw.count", b1.count, 3'd1);
        check("lw.opCode", b1.opCode, 6'h23);
        check("lw.rA", b1.rA, 5'd18);
        check("lw.rB", b1.rB, 5'd17);
        check("lw.imm_ext", b1.imm_ext, 32'h00000064);
        check("lw.tipo", b1.tipo, 2'b01);
        pop1();
        #1;
        check("lw.drained", b1.out_valid, 1'b0);

        // table of decode vectors
        for (int i = 0; i < 10; i++) begin
            push1(vecs[i].instr);
            check($sformatf("vec%0d.opCode", i), b1.opCode, vecs[i].op);
            check($sformatf("vec%0d.imm_ext", i), b1.imm_ext, vecs[i].imm);
            check($sformatf("vec%0d.tipo", i), b1.tipo, vecs[i].tipo);
            check_head($sformatf("vec%0d", i), vecs[i].instr);
            pop1();
        end

        // full FIFO: third word rejected, then push+pop keeps count at 2
        @(negedge clk);
        b1.in_valid = 1'b1; b1.instrucao = 32'h20010001;
        @(posedge clk);
        @(negedge clk);
        b1.instrucao = 32'h20020002;
        @(posedge clk);
        @(negedge clk);
        b1.instrucao = 32'h20030003;
        #1;
        check("full.count", b1.count, 3'd2);
        check("full.in_ready", b1.in_ready, 1'b0);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("full.count_hold", b1.count, 3'd2);
        check_head("full.head", 32'h20010001);
        b1.instrucao = 32'h20040004;
        b1.out_ready = 1'b1;
        #1;
        check("full.in_ready_pop", b1.in_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        b1.in_valid = 1'b0;
        #1;
        check("pushpop.count", b1.count, 3'd2);
        check_head("pushpop.head", 32'h20020002);
        @(posedge clk);
        @(negedge clk);
        #1;
        check_head("pushpop.tail", 32'h20040004);
        @(posedge clk);
        @(negedge clk);
        b1.out_ready = 1'b0;
        #1;
        check("drain.count", b1.count, 3'd0);

        // MODE 0: one capture for a full cont sweep
        b0.instrucao = 32'h08000010;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            b0.cont = 4'(c);
            @(posedge clk);
        end
        @(negedge clk);
        b0.cont = 4'd0;
        #1;
        check("mode0.count", b0.count, 3'd1);
        check("mode0.out_valid", b0.out_valid, 1'b1);
        check("mode0.jump", b0.jump, 26'h10);
        check("mode0.tipo", b0.tipo, 2'b10);

        // flush beats same-cycle push
        push1(32'h8E510064);
        push1(32'h3021FFFF);
        check("preflush.count", b1.count, 3'd2);
        b1.flush = 1'b1; b1.in_valid = 1'b1; b1.instrucao = 32'h2021FFFF;
        @(posedge clk);
        @(negedge clk);
        b1.flush = 1'b0; b1.in_valid = 1'b0;
        #1;
        check("flush.count", b1.count, 3'd0);
        check("flush.out_valid", b1.out_valid, 1'b0);

        // reset mid-stream
        push1(32'h8E510064);
        push1(32'h3021FFFF);
        rst = 1'b1;
        #1;
        check("midrst.in_ready", b1.in_ready, 1'b0);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("midrst.count", b1.count, 3'd0);
        check("midrst.out_valid", b1.out_valid, 1'b0);
        check("midrst.opCode", b1.opCode, 6'h00);
        check("midrst.imm_ext", b1.imm_ext, 32'h0);
        check("midrst.jump", b1.jump, 26'h0);
        check("midrst.mode0_count", b0.count, 3'd0);
        rst = 1'b0;

`ifdef DIVISOR_ILEGAL_EN
        push1(32'hFC000000);
        check("ilegal.bad_op", b1.ilegal, 1'b1);
        pop1();
        push1(32'h00221820);
        check("ilegal.add", b1.ilegal, 1'b0);
        pop1();
        push1(32'h0022183F);
        check("ilegal.bad_funct", b1.ilegal, 1'b1);
        pop1();
`endif

        // randomized traffic against the queue model
        q.delete();
        for (int n = 0; n < 400; n++) begin
            logic       iv;
            logic       ordy;
            logic       fl;
            logic       exp_rdy;
            logic [31:0] w;
            @(negedge clk);
            iv   = 1'($urandom_range(0, 1));
            ordy = 1'($urandom_range(0, 1));
            fl   = ($urandom_range(0, 19) == 0);
            w    = $urandom;
            if ($urandom_range(0, 3) == 0) w[31:26] = 6'h0C + 6'($urandom_range(0, 2));
            b1.in_valid = iv; b1.out_ready = ordy; b1.flush = fl; b1.instrucao = w;
            #1;
            exp_rdy = (q.size() < 2) || (q.size() > 0 && ordy);
            check("rnd.in_ready", b1.in_ready, exp_rdy);
            check("rnd.out_valid", b1.out_valid, q.size() != 0);
            check("rnd.count", b1.count, 3'(q.size()));
            if (q.size() > 0) check_head("rnd", q[0]);
            @(posedge clk);
            if (fl) begin
                q.delete();
            end else begin
                if (q.size() > 0 && ordy) void'(q.pop_front());
                if (iv && exp_rdy) q.push_back(w);
            end
        end
        @(negedge clk);
        b1.in_valid = 1'b0; b1.out_ready = 1'b0; b1.flush = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
